mult_hilo_unit: RTL and testbench
=================================

MULT_HILO_UNIT -- requirements
Module: mult_hilo_unit

Interface
REQ-001 Parameter WAIT_LIMIT, default 96, max cycles spent in WAIT before abort.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  multiply request, sampled in IDLE only.
REQ-005 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 op_a, op_b  input  32 each  operands, sampled with start.
REQ-007 wr_hi, wr_lo  input  1 each  direct writes to HI/LO (move-to-HI/LO).
REQ-008 wr_data  input  32  data for wr_hi/wr_lo.
REQ-009 mul_a, mul_b  output  32 each  unsigned operands to the downstream shift-add multiplier.
REQ-010 mul_go  output  1  drives multiplier doMult.
REQ-011 mul_reset  output  1  drives multiplier reset; equals reset combinationally.
REQ-012 mul_done  input  1  multiplier completion.
REQ-013 mul_prod  input  64  unsigned multiplier product, valid while mul_done=1.
REQ-014 hi, lo  output  32 each  HI/LO register contents.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse: HI/LO updated by a product.
REQ-017 timeout  output  1  one-cycle pulse: operation aborted.

Function
REQ-018 FSM states IDLE, LAUNCH, WAIT, DONE; all outputs registered except mul_reset and busy (decoded from state).
REQ-019 IDLE: start=1 -> latch operands, go LAUNCH; else stay.
REQ-020 Operand latch: unsigned -> mul_a=op_a, mul_b=op_b, neg=0; signed -> mul_a=|op_a|, mul_b=|op_b| (32-bit two's-complement negate when bit31=1), neg=op_a[31]^op_b[31].
REQ-021 |0x80000000| SHALL be 0x80000000 (valid unsigned magnitude, no overflow handling).
REQ-022 LAUNCH: mul_go=1 for exactly this one cycle; next state WAIT.
REQ-023 mul_a/mul_b SHALL hold stable from LAUNCH until return to IDLE.
REQ-024 WAIT: mul_go=0; wait counter increments each cycle from 0.
REQ-025 WAIT with mul_done=1: {hi,lo} <= neg ? (0 - mul_prod) mod 2^64 : mul_prod; next state DONE.
REQ-026 WAIT with counter = WAIT_LIMIT-1 and mul_done=0: HI/LO unchanged, timeout=1 next cycle, next state IDLE.
REQ-027 mul_done and counter limit in the same cycle: mul_done wins (capture, no timeout).
REQ-028 DONE: done=1 for exactly one cycle; unconditional transition to IDLE.
REQ-029 Latency: start at edge N -> LAUNCH N+1, WAIT N+2; mul_done at edge M -> done high M+1, IDLE M+2.
REQ-030 start while busy=1 SHALL be ignored (not queued).
REQ-031 mul_done outside WAIT SHALL be ignored.
REQ-032 wr_hi/wr_lo in IDLE write wr_data to HI/LO at next edge; ignored while busy=1.
REQ-033 wr_hi/wr_lo and start in the same IDLE cycle: write applies, start accepted; the later product overwrites both.
REQ-034 wr_hi and wr_lo together write the same wr_data to both.

Reset
REQ-035 reset=1 at an edge: state IDLE, hi=lo=0, mul_a=mul_b=0, mul_go=0, done=0, timeout=0, counter=0, neg=0; mul_reset=1 while reset=1.
REQ-036 reset overrides all inputs in any state, including mid-WAIT; in-flight product is discarded.

Verification
REQ-037 Unsigned 3 x 5, model returns 15 after 33 cycles -> hi=0x00000000, lo=0x0000000F, done one cycle, busy low after.
REQ-038 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-039 Signed 0xFFFFFFFE (-2) x 3 -> mul_a=2, mul_b=3; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-040 Signed 0x80000000 x 0x80000000 -> mul_a=mul_b=0x80000000; hi=0x40000000, lo=0x00000000.
REQ-041 start and wr_hi=1 (0x1234) during WAIT -> both ignored, mul_go stays 0, hi reflects product only; model never asserts mul_done -> timeout pulse after WAIT_LIMIT cycles, HI/LO unchanged.
REQ-042 reset during WAIT, then mul_done pulse in IDLE -> busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/mult_hilo_unit.sv
// HI/LO multiply front end: latches operands, drives an external unsigned shift-add
// multiplier, sign-corrects its product into HI/LO and aborts on a stalled multiplier.
module mult_hilo_unit #(
  parameter int WAIT_LIMIT = 96
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_is_signed,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic        i_wr_hi,
  input  logic        i_wr_lo,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  output logic        o_mul_go,
  output logic        o_mul_reset,
  input  logic        i_mul_done,
  input  logic [63:0] i_mul_prod,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [1:0]  o_state
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_mul_a, r_mul_b, r_hi, r_lo;
  logic        r_mul_go, r_done, r_timeout, r_neg;
  logic [CW-1:0] r_cnt;

  logic [31:0] w_abs_a, w_abs_b;
  logic [63:0] w_prod_fix;

  // Magnitudes wrap for 0x80000000, which is still the correct unsigned value.
  assign w_abs_a    = (i_is_signed && i_op_a[31]) ? (32'd0 - i_op_a) : i_op_a;
  assign w_abs_b    = (i_is_signed && i_op_b[31]) ? (32'd0 - i_op_b) : i_op_b;
  assign w_prod_fix = r_neg ? (64'd0 - i_mul_prod) : i_mul_prod;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mul_go  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_mul_go  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_wr_hi) r_hi <= i_wr_data;
          if (i_wr_lo) r_lo <= i_wr_data;
          if (i_start) begin
            r_mul_a  <= w_abs_a;
            r_mul_b  <= w_abs_b;
            r_neg    <= i_is_signed & (i_op_a[31] ^ i_op_b[31]);
            r_mul_go <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A product arriving on the last allowed cycle still counts.
          if (i_mul_done) begin
            {r_hi, r_lo} <= w_prod_fix;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
          end else if (r_cnt == CW'(WAIT_LIMIT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_mul_go    = r_mul_go;
  assign o_mul_reset = i_reset;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_timeout   = r_timeout;
  assign o_state     = r_state;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: a hand-driven multiplier stand-in supplies
// precomputed products; outputs are sampled on the falling edge.
module tb_mult_hilo_unit;

  localparam int WL = 96;

  logic        clk;
  logic        reset, start, is_signed, wr_hi, wr_lo, mul_done;
  logic [31:0] op_a, op_b, wr_data;
  logic [63:0] mul_prod;
  logic [31:0] mul_a, mul_b, hi, lo;
  logic        mul_go, mul_reset, busy, done, timeout;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  mult_hilo_unit #(.WAIT_LIMIT(WL)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_is_signed(is_signed),
    .i_op_a(op_a), .i_op_b(op_b), .i_wr_hi(wr_hi), .i_wr_lo(wr_lo),
    .i_wr_data(wr_data), .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_go(mul_go),
    .o_mul_reset(mul_reset), .i_mul_done(mul_done), .i_mul_prod(mul_prod),
    .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done), .o_timeout(timeout),
    .o_state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    total++; if (mul_reset !== 1'b1) begin bad++; $display("FAIL rst_mul_reset got=%b exp=1", mul_reset); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL rst_hilo got=%h exp=0", {hi, lo}); end
    total++; if ({mul_a, mul_b} !== 64'd0) begin bad++; $display("FAIL rst_mul_ab got=%h exp=0", {mul_a, mul_b}); end
    total++; if ({mul_go, done, timeout} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b exp=000", {mul_go, done, timeout}); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (mul_reset !== 1'b0) begin bad++; $display("FAIL rst_release got=%b exp=0", mul_reset); end
  endtask

  task automatic test_direct_write();
    wr_hi = 1'b1; wr_data = 32'hAAAA5555;
    @(negedge clk);
    wr_hi = 1'b0;
    total++; if ({hi, lo} !== 64'hAAAA5555_00000000) begin bad++; $display("FAIL wr_hi got=%h exp=aaaa555500000000", {hi, lo}); end
    wr_lo = 1'b1; wr_data = 32'h0F0F0F0F;
    @(negedge clk);
    wr_lo = 1'b0;
    total++; if ({hi, lo} !== 64'hAAAA5555_0F0F0F0F) begin bad++; $display("FAIL wr_lo got=%h exp=aaaa55550f0f0f0f", {hi, lo}); end
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h13579BDF;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    total++; if ({hi, lo} !== 64'h13579BDF_13579BDF) begin bad++; $display("FAIL wr_both got=%h exp=13579bdf13579bdf", {hi, lo}); end
  endtask

  // dly = WAIT cycles elapsed before the product is offered (counter value at mul_done).
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic [63:0] prod, input int dly, input logic wr_both,
                         input logic [31:0] ema, input logic [31:0] emb,
                         input logic [63:0] ehilo, input string nm);
    start = 1'b1; is_signed = sg; op_a = a; op_b = b;
    wr_hi = wr_both; wr_lo = wr_both; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; op_a = '0; op_b = '0; is_signed = 1'b0;
    total++; if ({mul_go, busy} !== 2'b11) begin bad++; $display("FAIL %s_launch go/busy got=%b exp=11", nm, {mul_go, busy}); end
    total++; if ({mul_a, mul_b} !== {ema, emb}) begin bad++; $display("FAIL %s_operands got=%h exp=%h", nm, {mul_a, mul_b}, {ema, emb}); end
    if (wr_both) begin
      total++; if ({hi, lo} !== 64'hDEADBEEF_DEADBEEF) begin bad++; $display("FAIL %s_wr_with_start got=%h exp=deadbeefdeadbeef", nm, {hi, lo}); end
    end
    @(negedge clk);
    total++; if ({mul_go, busy} !== 2'b01) begin bad++; $display("FAIL %s_wait go/busy got=%b exp=01", nm, {mul_go, busy}); end
    repeat (dly) @(negedge clk);
    total++; if ({done, timeout, busy} !== 3'b001) begin bad++; $display("FAIL %s_pre_done got=%b exp=001", nm, {done, timeout, busy}); end
    mul_done = 1'b1; mul_prod = prod;
    @(negedge clk);
    mul_done = 1'b0; mul_prod = '0;
    total++; if ({done, timeout, busy} !== 3'b101) begin bad++; $display("FAIL %s_done got=%b exp=101", nm, {done, timeout, busy}); end
    total++; if ({hi, lo} !== ehilo) begin bad++; $display("FAIL %s_hilo got=%h exp=%h", nm, {hi, lo}, ehilo); end
    total++; if ({mul_a, mul_b} !== {ema, emb}) begin bad++; $display("FAIL %s_hold got=%h exp=%h", nm, {mul_a, mul_b}, {ema, emb}); end
    @(negedge clk);
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL %s_idle done/busy got=%b exp=00", nm, {done, busy}); end
  endtask

  task automatic test_timeout();
    int n;
    start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; wr_hi = 1'b1; wr_data = 32'h00001234;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    total++; if ({mul_go, busy} !== 2'b01) begin bad++; $display("FAIL to_ignore_start got=%b exp=01", {mul_go, busy}); end
    total++; if (hi !== 32'h40000000) begin bad++; $display("FAIL to_ignore_wr got=%h exp=40000000", hi); end
    n = 2;
    while (!timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== WL + 1) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", n, WL + 1); end
    total++; if ({timeout, done, busy} !== 3'b100) begin bad++; $display("FAIL to_flags got=%b exp=100", {timeout, done, busy}); end
    total++; if ({hi, lo} !== 64'h40000000_00000000) begin bad++; $display("FAIL to_hilo got=%h exp=4000000000000000", {hi, lo}); end
    @(negedge clk);
    total++; if ({timeout, busy} !== 2'b00) begin bad++; $display("FAIL to_pulse got=%b exp=00", {timeout, busy}); end
  endtask

  task automatic test_reset_mid_wait();
    start = 1'b1; op_a = 32'd11; op_b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if ({busy, mul_reset, mul_go} !== 3'b010) begin bad++; $display("FAIL rmw_state got=%b exp=010", {busy, mul_reset, mul_go}); end
    total++; if ({hi, lo, mul_a, mul_b} !== 128'd0) begin bad++; $display("FAIL rmw_clear got=%h exp=0", {hi, lo, mul_a, mul_b}); end
    reset = 1'b0;
    mul_done = 1'b1; mul_prod = 64'd143;
    @(negedge clk);
    mul_done = 1'b0; mul_prod = '0;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rmw_stray_done got=%b exp=00", {busy, done}); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL rmw_hilo got=%h exp=0", {hi, lo}); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    mul_done = 1'b0; op_a = '0; op_b = '0; wr_data = '0; mul_prod = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_direct_write();
    do_mult(32'd3, 32'd5, 1'b0, 64'd15, 33, 1'b0, 32'd3, 32'd5,
            64'h00000000_0000000F, "u3x5");
    do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 5, 1'b0,
            32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "umax");
    do_mult(32'hFFFFFFFE, 32'd3, 1'b1, 64'd6, 0, 1'b0, 32'd2, 32'd3,
            64'hFFFFFFFF_FFFFFFFA, "sneg2x3");
    do_mult(32'd6, 32'd7, 1'b0, 64'd42, 3, 1'b1, 32'd6, 32'd7,
            64'h00000000_0000002A, "wr_start");
    do_mult(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, WL - 1, 1'b0,
            32'h80000000, 32'h80000000, 64'h40000000_00000000, "smin_limit");
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
